uart_fifo: RTL and testbench
============================

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 Parameter WIDTH, default 8: bits per entry.
REQ-002 Parameter DEPTH, default 16: number of entries; must be a power of two.
REQ-003 Parameter CNT_W, default 5: count width, equal to log2(DEPTH)+1.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port data_in, input, WIDTH bits: write data.
REQ-007 Port push, input, 1 bit: write request, one entry per cycle while high.
REQ-008 Port pop, input, 1 bit: read request, one entry per cycle while high.
REQ-009 Port fifo_reset, input, 1 bit: synchronous flush.
REQ-010 Port reset_status, input, 1 bit: clears the sticky error flags.
REQ-011 Port data_out, output, WIDTH bits: current head entry (first-word fall-through).
REQ-012 Port count, output, CNT_W bits: number of occupied entries, 0..DEPTH.
REQ-013 Port overrun, output, 1 bit: sticky flag, a push occurred while full.
REQ-014 Port underrun, output, 1 bit: sticky flag, a pop occurred while empty.
REQ-015 Port error_bit, output, 1 bit: an occupied entry carries error bits.

Function
REQ-016 Storage shall be DEPTH x WIDTH, with read pointer rd and write pointer wr, each log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-017 data_out shall combinationally equal mem[rd] with no read latency.
REQ-018 When empty, data_out shall show mem[rd], which is stale or reset data.
REQ-019 A push while count<DEPTH shall store data_in at wr, advance wr by 1 and increment count next cycle.
REQ-020 A pop while count>0 shall advance rd by 1 and decrement count next cycle; the popped value is the data_out seen during the pop cycle.
REQ-021 Push and pop together with 0<count<DEPTH shall both execute; count shall be unchanged.
REQ-022 Push and pop together with count==DEPTH shall both execute; count shall stay DEPTH; overrun shall not be set.
REQ-023 Push and pop together with count==0 shall store the push, ignore the pop and set underrun; count shall become 1.
REQ-024 A push alone while count==DEPTH shall be discarded with memory, wr and count unchanged, and shall set overrun.
REQ-025 A pop alone while count==0 shall leave rd and count unchanged and shall set underrun.
REQ-026 overrun and underrun shall hold until reset_status, fifo_reset or wb_rst_i.
REQ-027 If reset_status coincides with a new error event, the flag shall end the cycle set (set wins).
REQ-028 fifo_reset shall clear rd, wr, count, overrun and underrun next cycle, override push and pop that cycle, and leave memory contents unchanged.
REQ-029 For WIDTH>8, error_bit shall be the OR of bits [WIDTH-1:8] over all occupied entries; entries outside the occupied window are ignored.
REQ-030 For WIDTH==8, error_bit shall be constant 0.
REQ-031 count shall never exceed DEPTH or wrap below 0.

Reset
REQ-032 wb_rst_i high at a clock edge shall clear rd, wr, count, overrun, underrun and all memory entries to 0.
REQ-033 After reset: data_out=0, count=0, overrun=0, underrun=0, error_bit=0.
REQ-034 wb_rst_i shall have priority over fifo_reset, reset_status, push and pop.
REQ-035 Reset asserted mid-operation shall discard all contents within one cycle.

Verification
REQ-036 Scenario, FIFO order: after reset, push 0xA1, 0xB2, 0xC3 on consecutive cycles -> count=3, data_out=0xA1; three pops -> data_out 0xA1, 0xB2, 0xC3 in the pop cycles; count=0 at the end.
REQ-037 Scenario, full/overrun: push 17 values 0x00..0x10 -> count=16 and overrun=1 after the 17th; 16 pops return 0x00..0x0F; 0x10 is lost.
REQ-038 Scenario, underrun: pop on empty -> underrun=1 and count=0; reset_status pulse -> underrun=0 next cycle.
REQ-039 Scenario, simultaneous operations: at count=16, push 0x55 with pop -> count stays 16, overrun=0, and 0x55 is read last; at count=0, push 0x66 with pop -> count=1, data_out=0x66, underrun=1.
REQ-040 Scenario, wrap: 40 alternating push/pop pairs of incrementing data -> pointers wrap past 15 and every value reads back in order.
REQ-041 Scenario, flush: with count=5, pulse fifo_reset together with push -> count=0, flags=0, push ignored; with WIDTH=11, push 0x100 -> error_bit=1 until that entry is popped.

Source files
------------

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO for the UART datapath, with sticky overrun/underrun
// flags and an error summary over the error bits (above bit 7) of the occupied entries.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    input  logic             fifo_reset,
    input  logic             reset_status,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] count,
    output logic             overrun,
    output logic             underrun,
    output logic             error_bit
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd;
    logic [PTR_W-1:0] wr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             ovr_evt;
    logic             und_evt;

    // A push into a full FIFO still executes when a pop frees the head slot
    // in the same cycle; a pop from an empty FIFO never executes.
    always_comb begin
        full    = (count == FULL_CNT);
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || pop);
        ovr_evt = push && !pop && full;
        und_evt = pop && empty;
    end

    assign data_out = mem[rd];

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            rd       <= '0;
            wr       <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else if (fifo_reset) begin
            rd       <= '0;
            wr       <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr] <= data_in;
                wr      <= wr + 1'b1;
            end
            if (do_pop) begin
                rd <= rd + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error event wins over a coincident status clear.
            overrun  <= ovr_evt | (overrun & ~reset_status);
            underrun <= und_evt | (underrun & ~reset_status);
        end
    end

    if (WIDTH > 8) begin : g_err
        always_comb begin
            error_bit = 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if ((CNT_W'(k) < count) && (|mem[rd + PTR_W'(k)][WIDTH-1:8])) begin
                    error_bit = 1'b1;
                end
            end
        end
    end else begin : g_no_err
        assign error_bit = 1'b0;
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Randomized and directed bench for uart_fifo (WIDTH=11) against a queue-based
// reference model of the occupancy, ordering and sticky-flag rules.
module tb_uart_fifo;
    localparam int WIDTH = 11;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             wb_rst_i = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             fifo_reset = 1'b0;
    logic             reset_status = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] count;
    logic             overrun;
    logic             underrun;
    logic             error_bit;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    int unsigned q[$];
    bit          m_ovr = 1'b0;
    bit          m_und = 1'b0;

    uart_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .fifo_reset   (fifo_reset),
        .reset_status (reset_status),
        .data_out     (data_out),
        .count        (count),
        .overrun      (overrun),
        .underrun     (underrun),
        .error_bit    (error_bit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_err();
        foreach (q[i]) begin
            if ((q[i] >> 8) != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_update(input bit ps, input bit pp, input int unsigned d,
                                input bit fr, input bit rs, input bit rst);
        bit ev_o;
        bit ev_u;
        bit did_pop;
        if (rst || fr) begin
            q.delete();
            m_ovr = 1'b0;
            m_und = 1'b0;
        end else begin
            ev_o = ps && !pp && (q.size() == DEPTH);
            ev_u = pp && (q.size() == 0);
            did_pop = pp && (q.size() > 0);
            if (did_pop) void'(q.pop_front());
            if (ps && (q.size() < DEPTH)) q.push_back(d);
            if (ev_o) m_ovr = 1'b1;
            else if (rs) m_ovr = 1'b0;
            if (ev_u) m_und = 1'b1;
            else if (rs) m_und = 1'b0;
        end
    endtask

    task automatic check_state();
        check("count", count, q.size());
        check("overrun", overrun, m_ovr);
        check("underrun", underrun, m_und);
        check("error_bit", error_bit, model_err());
        if (q.size() > 0) check("data_out", data_out, q[0]);
    endtask

    task automatic step(input bit ps, input bit pp, input int unsigned d,
                        input bit fr = 1'b0, input bit rs = 1'b0, input bit rst = 1'b0);
        push = ps;
        pop = pp;
        data_in = WIDTH'(d);
        fifo_reset = fr;
        reset_status = rs;
        wb_rst_i = rst;
        @(posedge clk);
        model_update(ps, pp, d, fr, rs, rst);
        #1;
        push = 1'b0;
        pop = 1'b0;
        fifo_reset = 1'b0;
        reset_status = 1'b0;
        wb_rst_i = 1'b0;
        check_state();
    endtask

    initial begin
        #1;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("rst_data_out", data_out, 0);
        check("rst_count", count, 0);

        // FIFO order
        step(1, 0, 'hA1);
        step(1, 0, 'hB2);
        step(1, 0, 'hC3);
        check("order_count", count, 3);
        check("order_head", data_out, 'hA1);
        step(0, 1, 0);
        check("order_second", data_out, 'hB2);
        step(0, 1, 0);
        check("order_third", data_out, 'hC3);
        step(0, 1, 0);
        check("order_empty", count, 0);

        // Full and overrun
        for (int i = 0; i <= 16; i++) step(1, 0, i);
        check("full_count", count, 16);
        check("full_overrun", overrun, 1);
        for (int i = 0; i < 16; i++) begin
            check("full_drain", data_out, i);
            step(0, 1, 0);
        end
        check("full_drained", count, 0);

        // Underrun and status clear
        step(0, 0, 0, 0, 1);
        step(0, 1, 0);
        check("und_flag", underrun, 1);
        step(0, 0, 0, 0, 1);
        check("und_cleared", underrun, 0);

        // Status clear coinciding with a new underrun: set wins
        step(0, 1, 0, 0, 1);
        check("und_set_wins", underrun, 1);
        step(0, 0, 0, 0, 1);

        // Simultaneous operations at full and at empty
        for (int i = 0; i < 16; i++) step(1, 0, 'h20 + i);
        step(1, 1, 'h55);
        check("sim_full_count", count, 16);
        check("sim_full_ovr", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("sim_last", data_out, 'h55);
            step(0, 1, 0);
        end
        step(1, 1, 'h66);
        check("sim_empty_count", count, 1);
        check("sim_empty_head", data_out, 'h66);
        check("sim_empty_und", underrun, 1);
        step(0, 1, 0);
        step(0, 0, 0, 0, 1);

        // Pointer wrap
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 'h80 + i);
            check("wrap_head", data_out, 'h80 + i);
            step(0, 1, 0);
        end

        // Flush with push
        step(0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 'h40 + i);
        step(1, 0, 'h77, 1);
        check("flush_count", count, 0);
        check("flush_und", underrun, 0);
        check("flush_ovr", overrun, 0);

        // Error bit window
        step(1, 0, 'h011);
        step(1, 0, 'h100);
        check("err_set", error_bit, 1);
        step(0, 1, 0);
        check("err_still", error_bit, 1);
        step(0, 1, 0);
        check("err_clear", error_bit, 0);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) step(1, 0, 'h700 + i);
        step(1, 1, 'h3FF, 0, 0, 1);
        check("midrst_count", count, 0);
        check("midrst_data", data_out, 0);
        check("midrst_err", error_bit, 0);

        // Randomized traffic with push-heavy and pop-heavy phases
        for (int i = 0; i < 2000; i++) begin
            bit ps;
            bit pp;
            int unsigned d;
            if (((i / 120) % 2) == 0) begin
                ps = ($urandom_range(0, 99) < 70);
                pp = ($urandom_range(0, 99) < 35);
            end else begin
                ps = ($urandom_range(0, 99) < 35);
                pp = ($urandom_range(0, 99) < 70);
            end
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 255);
            step(ps, pp, d,
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
